// File: rtl/day11_pkg.sv
// Shared types and constants for the day-11 reactor path-count accelerator.
package day11_pkg;

  localparam int unsigned NODE_W = 15;

  localparam logic [7:0] ASCII_NL    = 8'h0A;
  localparam logic [7:0] ASCII_SP    = 8'h20;
  localparam logic [7:0] ASCII_COLON = 8'h3A;
  localparam logic [7:0] ASCII_LC_A  = 8'h61;
  localparam logic [7:0] ASCII_LC_Z  = 8'h7A;

  // "you" and "out" folded to {c0[4:0], c1[4:0], c2[4:0]}
  localparam logic [NODE_W-1:0] NODE_YOU = 15'b11001_01111_10101;
  localparam logic [NODE_W-1:0] NODE_OUT = 15'b01111_10101_10100;

  typedef enum logic [2:0] {
    ST_LOAD,
    ST_CLEAR,
    ST_INIT,
    ST_PASS,
    ST_DONE
  } state_e;

  typedef enum logic [1:0] {
    PH_EDGE,
    PH_READ,
    PH_WRITE
  } phase_e;

  typedef enum logic [2:0] {
    PS_SRC,
    PS_COLON,
    PS_SEP,
    PS_DST,
    PS_AFTER
  } pstate_e;

  typedef struct packed {
    logic [NODE_W-1:0] src;
    logic [NODE_W-1:0] dst;
  } edge_t;

  function automatic logic [NODE_W-1:0] node_id(input logic [7:0] c0,
                                                input logic [7:0] c1,
                                                input logic [7:0] c2);
    return {c0[4:0], c1[4:0], c2[4:0]};
  endfunction

  function automatic logic is_lower(input logic [7:0] b);
    return (b >= ASCII_LC_A) && (b <= ASCII_LC_Z);
  endfunction

endpackage

// File: rtl/user_logic_day11_line_parser.sv
// Turns the "sss: ddd ddd\n" byte stream into one edge strobe per destination.
module line_parser
  import day11_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       byte_valid,
  input  logic [7:0] byte_data,
  output logic       edge_valid,
  output edge_t      edge_data
);

  pstate_e           state_q, state_d;
  logic [1:0]        cnt_q, cnt_d;
  logic [NODE_W-1:0] acc_q, acc_d, src_q, src_d;
  logic              emit_d;
  edge_t             edge_d;

  logic              is_letter, is_sig;
  logic [NODE_W-1:0] acc_shift;

  assign is_letter = is_lower(byte_data);
  assign is_sig    = is_letter || (byte_data == ASCII_COLON) ||
                     (byte_data == ASCII_SP) || (byte_data == ASCII_NL);
  assign acc_shift = {acc_q[NODE_W-6:0], byte_data[4:0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= PS_SRC;
      cnt_q      <= '0;
      acc_q      <= '0;
      src_q      <= '0;
      edge_valid <= 1'b0;
      edge_data  <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      src_q      <= src_d;
      edge_valid <= emit_d;
      if (emit_d) edge_data <= edge_d;
    end
  end

  // Unrecognised bytes leave the parser untouched; misplaced significant bytes restart the line.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    src_d   = src_q;
    if (byte_valid) begin
      case (state_q)
        PS_SRC: begin
          if (is_letter) begin
            acc_d = acc_shift;
            if (cnt_q == 2'd2) begin
              src_d   = acc_shift;
              cnt_d   = '0;
              state_d = PS_COLON;
            end else begin
              cnt_d = cnt_q + 2'd1;
            end
          end else if (is_sig) begin
            cnt_d = '0;
          end
        end
        PS_COLON: begin
          if (byte_data == ASCII_COLON) begin
            state_d = PS_SEP;
          end else if (is_sig) begin
            state_d = PS_SRC;
            cnt_d   = '0;
          end
        end
        PS_SEP: begin
          if (byte_data == ASCII_SP) begin
            state_d = PS_DST;
            cnt_d   = '0;
          end else if (is_sig) begin
            state_d = PS_SRC;
            cnt_d   = '0;
          end
        end
        PS_DST: begin
          if (is_letter) begin
            acc_d = acc_shift;
            if (cnt_q == 2'd2) begin
              cnt_d   = '0;
              state_d = PS_AFTER;
            end else begin
              cnt_d = cnt_q + 2'd1;
            end
          end else if ((byte_data == ASCII_SP) && (cnt_q == 2'd0)) begin
            state_d = PS_DST;
          end else if (is_sig) begin
            state_d = PS_SRC;
            cnt_d   = '0;
          end
        end
        PS_AFTER: begin
          if (byte_data == ASCII_SP) begin
            state_d = PS_DST;
            cnt_d   = '0;
          end else if (is_sig) begin
            state_d = PS_SRC;
            cnt_d   = '0;
          end
        end
        default: begin
          state_d = PS_SRC;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_comb begin
    emit_d     = byte_valid && (state_q == PS_DST) && is_letter && (cnt_q == 2'd2);
    edge_d     = '0;
    edge_d.src = src_q;
    edge_d.dst = acc_shift;
  end

endmodule

// File: rtl/user_logic_day11.sv
// JTAG USER4 accelerator: loads the device graph, counts paths you->out by layered passes.
module user_logic_day11
  import day11_pkg::*;
#(
  parameter int unsigned RESULT_WIDTH = 16,
  parameter int unsigned MAX_EDGES    = 4096,
  parameter int unsigned IDLE_START   = 8,
  parameter int unsigned TAG_WIDTH    = 8,
  parameter int unsigned NODE_BITS    = NODE_W
) (
  input  logic tck,
  input  logic test_logic_reset,
  input  logic tdi,
  output logic tdo,
  input  logic run_test_idle,
  input  logic ir_is_user,
  input  logic capture_dr,
  input  logic shift_dr,
  input  logic update_dr
);

  localparam int unsigned WAY_W = TAG_WIDTH + RESULT_WIDTH;
  localparam int unsigned EA_W  = $clog2(MAX_EDGES);
  localparam int unsigned EC_W  = $clog2(MAX_EDGES + 1);
  localparam int unsigned IC_W  = $clog2(IDLE_START + 1);
  localparam int unsigned WAYS  = 2 ** NODE_BITS;
  localparam logic [TAG_WIDTH-1:0] PASS_LAST = '1;

  logic rst_n;
  assign rst_n = ~test_logic_reset;

  state_e                  state_q, state_d;
  phase_e                  phase_q;
  logic [7:0]              in_sr;
  logic [RESULT_WIDTH-1:0] out_sr, result_q, total_q;
  logic [TAG_WIDTH-1:0]    pass_q;
  logic                    cur_is_b_q, any_c_q;
  logic [EC_W-1:0]         edge_cnt_q, edge_idx_q;
  logic [NODE_BITS-1:0]    clr_addr_q;
  logic [IC_W-1:0]         idle_cnt_q;

  edge_t                   edge_ram [MAX_EDGES];
  edge_t                   edge_q;
  logic [WAY_W-1:0]        ram_a [WAYS];
  logic [WAY_W-1:0]        ram_b [WAYS];
  logic [WAY_W-1:0]        a_q, b_q;

  logic                    p_valid, edge_we;
  edge_t                   p_edge;

  logic                    trigger, pass_end, c_nz, do_upd;
  logic [WAY_W-1:0]        cur_w, nxt_w, upd_w;
  logic [RESULT_WIDTH-1:0] c_val, nsum;
  logic [TAG_WIDTH-1:0]    pass_nx;
  logic [NODE_BITS-1:0]    e_src, e_dst;

  logic                    we_a, we_b;
  logic [NODE_BITS-1:0]    addr_a, addr_b;
  logic [WAY_W-1:0]        wd_a, wd_b;

  line_parser u_parser (
    .clk        (tck),
    .rst_n      (rst_n),
    .byte_valid (ir_is_user && update_dr && (state_q == ST_LOAD)),
    .byte_data  (in_sr),
    .edge_valid (p_valid),
    .edge_data  (p_edge)
  );

  assign tdo     = out_sr[0];
  assign edge_we = (state_q == ST_LOAD) && p_valid && (edge_cnt_q != EC_W'(MAX_EDGES));
  assign trigger = (state_q == ST_LOAD) && run_test_idle &&
                   (idle_cnt_q >= IC_W'(IDLE_START - 1)) && (edge_cnt_q != '0);
  assign pass_end = (phase_q == PH_EDGE) && (edge_idx_q == edge_cnt_q);

  // cur/next roles alternate between the two ways RAMs every pass
  assign cur_w   = cur_is_b_q ? b_q : a_q;
  assign nxt_w   = cur_is_b_q ? a_q : b_q;
  assign pass_nx = pass_q + TAG_WIDTH'(1);
  assign c_val   = (cur_w[WAY_W-1 -: TAG_WIDTH] == pass_q) ? cur_w[RESULT_WIDTH-1:0] : '0;
  assign nsum    = ((nxt_w[WAY_W-1 -: TAG_WIDTH] == pass_nx) ? nxt_w[RESULT_WIDTH-1:0] : '0) + c_val;
  assign upd_w   = {pass_nx, nsum};
  assign c_nz    = (c_val != '0);
  assign do_upd  = (state_q == ST_PASS) && (phase_q == PH_WRITE) && c_nz;
  assign e_src   = edge_q.src[NODE_BITS-1:0];
  assign e_dst   = edge_q.dst[NODE_BITS-1:0];

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_LOAD:  if (trigger) state_d = ST_CLEAR;
      ST_CLEAR: if (clr_addr_q == '1) state_d = ST_INIT;
      ST_INIT:  state_d = ST_PASS;
      ST_PASS:  if (pass_end && (!any_c_q || (pass_q == PASS_LAST))) state_d = ST_DONE;
      ST_DONE:  state_d = ST_DONE;
      default:  state_d = ST_LOAD;
    endcase
  end

  always_comb begin
    we_a   = 1'b0;
    we_b   = 1'b0;
    wd_a   = upd_w;
    wd_b   = upd_w;
    addr_a = cur_is_b_q ? e_dst : e_src;
    addr_b = cur_is_b_q ? e_src : e_dst;
    case (state_q)
      ST_CLEAR: begin
        we_a   = 1'b1;
        we_b   = 1'b1;
        wd_a   = '0;
        wd_b   = '0;
        addr_a = clr_addr_q;
        addr_b = clr_addr_q;
      end
      ST_INIT: begin
        we_a   = 1'b1;
        wd_a   = {TAG_WIDTH'(1), RESULT_WIDTH'(1)};
        addr_a = NODE_YOU[NODE_BITS-1:0];
      end
      ST_PASS: begin
        we_a = do_upd && cur_is_b_q;
        we_b = do_upd && !cur_is_b_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge tck or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_LOAD;
      phase_q    <= PH_EDGE;
      in_sr      <= '0;
      out_sr     <= '0;
      result_q   <= '0;
      total_q    <= '0;
      pass_q     <= '0;
      cur_is_b_q <= 1'b0;
      any_c_q    <= 1'b0;
      edge_cnt_q <= '0;
      edge_idx_q <= '0;
      clr_addr_q <= '0;
      idle_cnt_q <= '0;
    end else begin
      state_q <= state_d;

      if (ir_is_user && shift_dr) in_sr <= {tdi, in_sr[7:1]};
      if (ir_is_user && capture_dr) out_sr <= result_q;
      else if (ir_is_user && shift_dr) out_sr <= {tdi, out_sr[RESULT_WIDTH-1:1]};

      if (!run_test_idle) idle_cnt_q <= '0;
      else if (idle_cnt_q != IC_W'(IDLE_START)) idle_cnt_q <= idle_cnt_q + IC_W'(1);

      if (edge_we) edge_cnt_q <= edge_cnt_q + EC_W'(1);

      case (state_q)
        ST_LOAD:  clr_addr_q <= '0;
        ST_CLEAR: clr_addr_q <= clr_addr_q + NODE_BITS'(1);
        ST_INIT: begin
          pass_q     <= TAG_WIDTH'(1);
          total_q    <= '0;
          cur_is_b_q <= 1'b0;
          any_c_q    <= 1'b0;
          edge_idx_q <= '0;
          phase_q    <= PH_EDGE;
        end
        ST_PASS: begin
          case (phase_q)
            PH_EDGE: begin
              if (pass_end) begin
                cur_is_b_q <= ~cur_is_b_q;
                pass_q     <= pass_nx;
                edge_idx_q <= '0;
                any_c_q    <= 1'b0;
              end else begin
                phase_q <= PH_READ;
              end
            end
            PH_READ: phase_q <= PH_WRITE;
            default: begin
              if (c_nz) begin
                any_c_q <= 1'b1;
                if (edge_q.dst == NODE_OUT) total_q <= total_q + c_val;
              end
              edge_idx_q <= edge_idx_q + EC_W'(1);
              phase_q    <= PH_EDGE;
            end
          endcase
        end
        default: ;
      endcase

      if ((state_q == ST_PASS) && (state_d == ST_DONE)) result_q <= total_q;
    end
  end

  // Edge list: written in order during load, read one entry per edge step.
  always_ff @(posedge tck) begin
    if (edge_we) edge_ram[edge_cnt_q[EA_W-1:0]] <= p_edge;
    edge_q <= edge_ram[edge_idx_q[EA_W-1:0]];
  end

  always_ff @(posedge tck) begin
    if (we_a) ram_a[addr_a] <= wd_a;
    a_q <= ram_a[addr_a];
    if (we_b) ram_b[addr_b] <= wd_b;
    b_q <= ram_b[addr_b];
  end

endmodule

// File: tb/tb_user_logic_day11.sv
// Directed bench: loads puzzle texts over emulated DR scans and reads back path counts.
module tb_user_logic_day11;

  localparam int unsigned NB   = 10;
  localparam int unsigned IDLE = 8;

  logic tck = 1'b0;
  logic test_logic_reset, tdi, tdo, run_test_idle, ir_is_user;
  logic capture_dr, shift_dr, update_dr;

  int n_tests = 0;
  int n_fail  = 0;

  user_logic_day11 #(.NODE_BITS(NB), .IDLE_START(IDLE)) dut (
    .tck              (tck),
    .test_logic_reset (test_logic_reset),
    .tdi              (tdi),
    .tdo              (tdo),
    .run_test_idle    (run_test_idle),
    .ir_is_user       (ir_is_user),
    .capture_dr       (capture_dr),
    .shift_dr         (shift_dr),
    .update_dr        (update_dr)
  );

  always #5 tck = ~tck;

  typedef struct {
    string       name;
    string       text;
    int          edges;
    int          depth;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs [6];

  localparam string EX_A = "aaa: you hhh\nyou: bbb ccc\nbbb: ddd eee\nccc: ddd eee fff\nddd: ggg\n";
  localparam string EX_B = "eee: out\nfff: out\nggg: out\nhhh: ccc fff iii\niii: out\n";

  function automatic vec_t mk(input string nm, input string txt, input int e, input int d,
                              input logic [15:0] x);
    vec_t v;
    v.name = nm; v.text = txt; v.edges = e; v.depth = d; v.exp = x;
    return v;
  endfunction

  function automatic string diamonds(input int n);
    string s, src, nxt;
    byte   l;
    s = "";
    for (int i = 0; i < n; i++) begin
      l = byte'(8'h61 + i);
      if (i == 0) src = "you";
      else src = $sformatf("d%cj", l);
      if (i == n - 1) nxt = "out";
      else nxt = $sformatf("d%cj", byte'(l + 8'd1));
      s = {s, $sformatf("%s: d%ck d%cl\nd%ck: %s\nd%cl: %s\n", src, l, l, l, nxt, l, nxt)};
    end
    return s;
  endfunction

  task automatic tick();
    @(posedge tck);
    #1;
  endtask

  task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%04h, expected 0x%04h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    test_logic_reset = 1'b1;
    tick();
    tick();
    test_logic_reset = 1'b0;
    tick();
  endtask

  task automatic scan_byte(input byte b);
    ir_is_user = 1'b1;
    capture_dr = 1'b1;
    tick();
    capture_dr = 1'b0;
    shift_dr   = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tdi = b[i];
      tick();
    end
    shift_dr  = 1'b0;
    tdi       = 1'b0;
    update_dr = 1'b1;
    tick();
    update_dr = 1'b0;
    tick();
  endtask

  task automatic send(input string s);
    for (int i = 0; i < s.len(); i++) scan_byte(s[i]);
  endtask

  task automatic readback(output logic [15:0] v);
    ir_is_user = 1'b1;
    capture_dr = 1'b1;
    tick();
    capture_dr = 1'b0;
    shift_dr   = 1'b1;
    tdi        = 1'b0;
    for (int j = 0; j < 16; j++) begin
      v[j] = tdo;
      tick();
    end
    shift_dr  = 1'b0;
    update_dr = 1'b1;
    tick();
    update_dr = 1'b0;
    tick();
  endtask

  task automatic idle(input int n);
    run_test_idle = 1'b1;
    repeat (n) tick();
    run_test_idle = 1'b0;
    tick();
  endtask

  // Worst-case compute latency for E edges and longest path depth.
  task automatic wait_compute(input int e, input int depth);
    repeat ((1 << NB) + 4 + (depth + 2) * (4 * e + 2) + 32) tick();
  endtask

  task automatic run_vec(input vec_t v);
    logic [15:0] r;
    do_reset();
    check({v.name, "_tdo_rst"}, {15'b0, tdo}, 16'h0000);
    idle(IDLE + 4);
    readback(r);
    check({v.name, "_rb_empty"}, r, 16'h0000);
    send(v.text);
    idle(IDLE);
    repeat (4) tick();
    readback(r);
    check({v.name, "_rb_clear"}, r, 16'h0000);
    wait_compute(v.edges, v.depth);
    readback(r);
    check({v.name, "_result"}, r, v.exp);
    send("you: out\n");
    readback(r);
    check({v.name, "_hold"}, r, v.exp);
  endtask

  initial begin
    logic [15:0] r;
    test_logic_reset = 1'b1;
    tdi = 1'b0; run_test_idle = 1'b0; ir_is_user = 1'b0;
    capture_dr = 1'b0; shift_dr = 1'b0; update_dr = 1'b0;

    vecs[0] = mk("example", {EX_A, EX_B}, 17, 4, 16'd5);
    vecs[1] = mk("single", "you: out\n", 1, 1, 16'd1);
    vecs[2] = mk("crlf", "you: aaa bbb\r\naaa: out\r\nbbb: out\r\n", 4, 2, 16'd2);
    vecs[3] = mk("malformed", "you: aaa\nqq: 7out\naaa: out\n", 2, 2, 16'd1);
    vecs[4] = mk("diamond3", diamonds(3), 12, 6, 16'd8);
    vecs[5] = mk("diamond17", diamonds(17), 68, 34, 16'd0);

    for (int i = 0; i < 6; i++) run_vec(vecs[i]);

    // Reset mid-stream, short idle bursts must not trigger, resend must not see stale edges.
    do_reset();
    send(EX_A);
    idle(IDLE - 1);
    test_logic_reset = 1'b1;
    tick();
    test_logic_reset = 1'b0;
    tick();
    check("midrst_tdo", {15'b0, tdo}, 16'h0000);
    readback(r);
    check("midrst_rb", r, 16'h0000);
    send(EX_A);
    idle(IDLE - 1);
    send(EX_B);
    idle(IDLE);
    wait_compute(17, 4);
    readback(r);
    check("midrst_result", r, 16'd5);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
